// File: rtl/riscv_ctrl_pkg.sv
// Shared definitions for the core run controller: FSM encoding, halt opcodes
// and the default instruction-memory depth.
package riscv_ctrl_pkg;

    localparam int unsigned IMEM_DEPTH_DEFAULT = 1024;

    localparam logic [31:0] INSTR_ECALL  = 32'h0000_0073;
    localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StFlush,
        StRun,
        StDone
    } ctrl_state_e;

    function automatic logic is_halt_instr(input logic [31:0] instr);
        return (instr == INSTR_ECALL) || (instr == INSTR_EBREAK);
    endfunction

endpackage

// File: rtl/run_watchdog.sv
// Saturating run-cycle counter with a limit latched at run start; expire_o
// flags the edge at which the count reaches the limit (limit 0 disables).
module run_watchdog #(
    parameter int unsigned CW = 32
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          clear_i,
    input  logic          enable_i,
    input  logic          load_limit_i,
    input  logic [CW-1:0] limit_i,
    output logic [CW-1:0] count_o,
    output logic          expire_o
);

    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] limit_q, limit_d;

    always_comb begin
        count_d = count_q;
        limit_d = limit_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i && (count_q != {CW{1'b1}})) begin
            count_d = count_q + CW'(1);
        end
        if (load_limit_i) begin
            limit_d = limit_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
            limit_q <= '0;
        end else begin
            count_q <= count_d;
            limit_q <= limit_d;
        end
    end

    // A saturated count never matches: the wrapped sum is 0 and limit 0 is "disabled".
    assign expire_o = enable_i && (limit_q != '0) && ((count_q + CW'(1)) == limit_q);
    assign count_o  = count_q;

endmodule

// File: rtl/core_run_ctrl.sv
// Run controller: streams a program image into instruction memory, releases the
// core from reset, and stops it on ECALL/EBREAK or when the watchdog expires.
module core_run_ctrl
    import riscv_ctrl_pkg::*;
#(
    parameter int unsigned IMEM_DEPTH = IMEM_DEPTH_DEFAULT,
    parameter int unsigned AW         = $clog2(IMEM_DEPTH),
    parameter int unsigned CW         = 32
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          start_i,
    input  logic          ld_valid_i,
    output logic          ld_ready_o,
    input  logic [31:0]   ld_data_i,
    input  logic          ld_last_i,
    output logic          imem_we_o,
    output logic [AW-1:0] imem_addr_o,
    output logic [31:0]   imem_wdata_o,
    output logic          core_rst_no,
    input  logic [31:0]   core_pc_i,
    input  logic [31:0]   core_instr_i,
    input  logic [CW-1:0] max_cycles_i,
    output logic          busy_o,
    output logic          done_o,
    output logic          timeout_o,
    output logic [CW-1:0] cycle_count_o,
    output logic [AW:0]   words_loaded_o,
    output logic [31:0]   halt_pc_o
);

    localparam logic [AW:0] LAST_BEAT_IDX = (AW+1)'(IMEM_DEPTH - 1);

    ctrl_state_e state_q, state_d;

    logic          imem_we_q, imem_we_d;
    logic [AW-1:0] imem_addr_q, imem_addr_d;
    logic [31:0]   imem_wdata_q, imem_wdata_d;
    logic          core_rst_q, core_rst_d;
    logic          timeout_q, timeout_d;
    logic [AW:0]   words_loaded_q, words_loaded_d;
    logic [31:0]   halt_pc_q, halt_pc_d;

    logic in_run;
    logic load_entry;
    logic ld_fire;
    logic last_beat;
    logic halt;
    logic expire;

    assign in_run     = (state_q == StRun);
    assign load_entry = start_i && ((state_q == StIdle) || (state_q == StDone));
    assign ld_fire    = (state_q == StLoad) && ld_valid_i;
    // Beat number IMEM_DEPTH closes the image even without ld_last.
    assign last_beat  = ld_fire && (ld_last_i || (words_loaded_q == LAST_BEAT_IDX));
    assign halt       = in_run && is_halt_instr(core_instr_i);

    run_watchdog #(
        .CW(CW)
    ) u_run_watchdog (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .clear_i     (load_entry),
        .enable_i    (in_run),
        .load_limit_i(state_q == StFlush),
        .limit_i     (max_cycles_i),
        .count_o     (cycle_count_o),
        .expire_o    (expire)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start_i) state_d = StLoad;
            StLoad:  if (last_beat) state_d = StFlush;
            StFlush: state_d = StRun;
            StRun:   if (halt || expire) state_d = StDone;
            StDone:  if (start_i) state_d = StLoad;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        ld_ready_o = (state_q == StLoad);
        busy_o     = (state_q == StLoad) || (state_q == StFlush) || (state_q == StRun);
        done_o     = (state_q == StDone);
    end

    always_comb begin
        imem_we_d      = ld_fire;
        imem_addr_d    = imem_addr_q;
        imem_wdata_d   = imem_wdata_q;
        words_loaded_d = words_loaded_q;
        timeout_d      = timeout_q;
        halt_pc_d      = halt_pc_q;
        core_rst_d     = (state_d == StRun);
        if (load_entry) begin
            words_loaded_d = '0;
            timeout_d      = 1'b0;
            halt_pc_d      = '0;
        end
        if (ld_fire) begin
            imem_addr_d    = words_loaded_q[AW-1:0];
            imem_wdata_d   = ld_data_i;
            words_loaded_d = words_loaded_q + (AW+1)'(1);
        end
        // Halt takes priority over a coincident watchdog expiry.
        if (halt) begin
            halt_pc_d = core_pc_i;
        end else if (expire) begin
            timeout_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            imem_we_q      <= 1'b0;
            imem_addr_q    <= '0;
            imem_wdata_q   <= '0;
            core_rst_q     <= 1'b0;
            timeout_q      <= 1'b0;
            words_loaded_q <= '0;
            halt_pc_q      <= '0;
        end else begin
            imem_we_q      <= imem_we_d;
            imem_addr_q    <= imem_addr_d;
            imem_wdata_q   <= imem_wdata_d;
            core_rst_q     <= core_rst_d;
            timeout_q      <= timeout_d;
            words_loaded_q <= words_loaded_d;
            halt_pc_q      <= halt_pc_d;
        end
    end

    assign imem_we_o      = imem_we_q;
    assign imem_addr_o    = imem_addr_q;
    assign imem_wdata_o   = imem_wdata_q;
    assign core_rst_no    = core_rst_q;
    assign timeout_o      = timeout_q;
    assign words_loaded_o = words_loaded_q;
    assign halt_pc_o      = halt_pc_q;

endmodule
